// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: configurable width/parity, false-start, parity and stop checks,
// held output word with valid/ready handshake. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_frame #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CLK_DIV    = 1
) (
  input  logic                 scan_clk,
  input  logic                 Reset,
  input  logic                 UART_RX,
  input  logic                 RX_READY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 RX_PERR,
  output logic                 RX_FERR,
  output logic                 RX_OVERRUN,
  output logic                 RX_BUSY
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q;
  logic [DivW-1:0]      div_q;
  logic                 rx_m_q, rx_s, rx_prev_q;
  logic                 tick;
  logic                 samp_bit;
  logic                 bit_end;

  always_ff @(posedge scan_clk) begin
    if (Reset) begin
      rx_m_q    <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_m_q    <= UART_RX;
      rx_s      <= rx_m_q;
      rx_prev_q <= rx_s;
    end
  end

  assign tick = (div_q == DivW'(CLK_DIV - 1));

  always_ff @(posedge scan_clk) begin
    if (Reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one tick past centre so the window is centre-1, centre, centre+1.
  localparam int unsigned StartDec = OVERSAMPLE / 2;
  logic [1:0] maj_q;

  always_ff @(posedge scan_clk) begin
    if (Reset) begin
      maj_q <= 2'b11;
    end else if (tick) begin
      maj_q <= {maj_q[0], rx_s};
    end
  end

  assign samp_bit = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
`else
  localparam int unsigned StartDec = OVERSAMPLE / 2 - 1;
  assign samp_bit = rx_s;
`endif

  // Sample points after the start decision are spaced one full bit apart.
  assign bit_end = (cnt_q == CntW'(OVERSAMPLE - 1));
  assign RX_BUSY = (state_q != StIdle);

  always_ff @(posedge scan_clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      RX_PERR    <= 1'b0;
      RX_FERR    <= 1'b0;
      RX_OVERRUN <= 1'b0;
    end else begin
      if (RX_VALID && RX_READY) begin
        RX_VALID   <= 1'b0;
        RX_OVERRUN <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            if (cnt_q == CntW'(StartDec)) begin
              cnt_q     <= '0;
              bit_cnt_q <= '0;
              state_q   <= samp_bit ? StIdle : StData;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StData: begin
          if (tick) begin
            if (bit_end) begin
              cnt_q   <= '0;
              shreg_q <= {samp_bit, shreg_q[DATA_BITS-1:1]};
              if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                bit_cnt_q <= '0;
                state_q   <= (PARITY != 0) ? StParity : StStop;
              end else begin
                bit_cnt_q <= bit_cnt_q + BitW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StParity: begin
          if (tick) begin
            if (bit_end) begin
              cnt_q   <= '0;
              perr_q  <= ((^shreg_q) ^ samp_bit) != (PARITY == 1);
              state_q <= StStop;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (bit_end) begin
              cnt_q   <= '0;
              state_q <= StIdle;
              // Accepting the old word this cycle frees the slot, so it is not an overrun.
              if (!RX_VALID || RX_READY) begin
                RX_DATA  <= shreg_q;
                RX_PERR  <= perr_q;
                RX_FERR  <= ~samp_bit;
                RX_VALID <= 1'b1;
              end else begin
                RX_OVERRUN <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and an even-parity instance.
module tb_uart_rx_frame;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT        = 155;
  localparam int FS_EDGE    = 12;
  localparam int GLITCH_EXP = 32'h00;
`else
  localparam int LAT        = 154;
  localparam int FS_EDGE    = 11;
  localparam int GLITCH_EXP = 32'h08;
`endif

  logic       clk;
  logic       Reset;
  logic       rx0, rx1, rdy0, rdy1;
  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d0_perr, d0_ferr, d0_ovr, d0_busy;
  logic       d1_valid, d1_perr, d1_ferr, d1_ovr, d1_busy;

  uart_rx_frame #(.DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16), .CLK_DIV(1)) dut0 (
    .scan_clk(clk), .Reset(Reset), .UART_RX(rx0), .RX_READY(rdy0), .RX_DATA(d0_data),
    .RX_VALID(d0_valid), .RX_PERR(d0_perr), .RX_FERR(d0_ferr), .RX_OVERRUN(d0_ovr),
    .RX_BUSY(d0_busy)
  );

  uart_rx_frame #(.DATA_BITS(8), .PARITY(2), .OVERSAMPLE(16), .CLK_DIV(1)) dut1 (
    .scan_clk(clk), .Reset(Reset), .UART_RX(rx1), .RX_READY(rdy1), .RX_DATA(d1_data),
    .RX_VALID(d1_valid), .RX_PERR(d1_perr), .RX_FERR(d1_ferr), .RX_OVERRUN(d1_ovr),
    .RX_BUSY(d1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Word monitor: count RX_VALID rising edges and high cycles, note rise time.
  int   words0 = 0, words1 = 0, hi0 = 0, rise0 = 0;
  logic v0_prev = 1'b0, v1_prev = 1'b0;
  always @(negedge clk) begin
    if (d0_valid && !v0_prev) begin
      words0++;
      rise0 = cyc;
    end
    if (d0_valid) hi0++;
    if (d1_valid && !v1_prev) words1++;
    v0_prev = d0_valid;
    v1_prev = d1_valid;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int lane, input logic v);
    if (lane == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Drive nbits LSB first, 16 cycles each; optionally invert one cycle of one bit.
  task automatic send(input int lane, input logic [15:0] bits, input int nbits,
                      input int gbit, input int goff);
    for (int b = 0; b < nbits; b++) begin
      for (int s = 0; s < 16; s++) begin
        logic v;
        v = bits[b];
        if (b == gbit && s == goff) v = ~v;
        set_line(lane, v);
        @(negedge clk);
      end
    end
  endtask

  int w0, w1, h0, c0;

  initial begin
    rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; Reset = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_out0", 32'({d0_data, d0_valid, d0_perr, d0_ferr, d0_ovr, d0_busy}), 32'd0);
    check("reset_out1", 32'({d1_data, d1_valid, d1_perr, d1_ferr, d1_ovr, d1_busy}), 32'd0);
    Reset = 1'b0;
    repeat (20) @(negedge clk);

    // 8N1 0xA5, ready high
    w0 = words0; h0 = hi0; c0 = cyc;
    send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, 0);
    repeat (10) @(negedge clk);
    check("a5_data", 32'(d0_data), 32'hA5);
    check("a5_errs", 32'({d0_perr, d0_ferr}), 32'd0);
    check("a5_words", 32'(words0 - w0), 32'd1);
    check("a5_valid_cycles", 32'(hi0 - h0), 32'd1);
    check("a5_latency", 32'(rise0 - (c0 + 1)), 32'(LAT));

    // Even parity: 0x07 has three ones, so correct parity bit is 1
    w1 = words1;
    send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 0);
    repeat (10) @(negedge clk);
    check("par_bad_data", 32'(d1_data), 32'h07);
    check("par_bad_perr", 32'(d1_perr), 32'd1);
    send(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 0);
    repeat (10) @(negedge clk);
    check("par_good_perr", 32'(d1_perr), 32'd0);
    check("par_words", 32'(words1 - w1), 32'd2);

    // Stop bit 0 then line stuck low for 40 bit times: one framing-error word only
    w0 = words0;
    send(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10, -1, 0);
    repeat (40 * 16) @(negedge clk);
    check("ferr_data", 32'(d0_data), 32'h3C);
    check("ferr_flag", 32'(d0_ferr), 32'd1);
    check("ferr_words", 32'(words0 - w0), 32'd1);
    check("ferr_idle_low", 32'(d0_busy), 32'd0);
    rx0 = 1'b1;
    repeat (16) @(negedge clk);
    send(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1, 0);
    repeat (10) @(negedge clk);
    check("after_ferr_data", 32'(d0_data), 32'h5A);
    check("after_ferr_flag", 32'(d0_ferr), 32'd0);
    check("after_ferr_words", 32'(words0 - w0), 32'd2);

    // Overrun: ready low, two back-to-back frames
    rdy0 = 1'b0;
    send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1, 0);
    send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, -1, 0);
    repeat (10) @(negedge clk);
    check("ovr_data", 32'(d0_data), 32'h11);
    check("ovr_valid", 32'(d0_valid), 32'd1);
    check("ovr_flag", 32'(d0_ovr), 32'd1);
    rdy0 = 1'b1;
    @(negedge clk);
    check("ovr_valid_clr", 32'(d0_valid), 32'd0);
    check("ovr_flag_clr", 32'(d0_ovr), 32'd0);
    check("ovr_data_hold", 32'(d0_data), 32'h11);
    repeat (20) @(negedge clk);

    // False start: 4-tick low pulse
    w0 = words0; c0 = cyc;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (FS_EDGE - 1 - 4) @(negedge clk);
    check("fs_busy_before", 32'(d0_busy), 32'd1);
    @(negedge clk);
    check("fs_busy_after", 32'(d0_busy), 32'd0);
    repeat (200) @(negedge clk);
    check("fs_words", 32'(words0 - w0), 32'd0);

    // Reset mid-byte aborts the frame
    w0 = words0;
    send(0, 16'h0000, 6, -1, 0);
    rx0 = 1'b1; Reset = 1'b1;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    check("midrst_out", 32'({d0_data, d0_valid, d0_perr, d0_ferr, d0_ovr, d0_busy}), 32'd0);
    repeat (200) @(negedge clk);
    check("midrst_words", 32'(words0 - w0), 32'd0);

    // One-cycle high glitch at the centre of data bit 3
    send(0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 4, 8);
    repeat (10) @(negedge clk);
    check("glitch_data", 32'(d0_data), 32'(GLITCH_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
